// File: rtl/address_bus_demux_pkg.sv
// Shared types and record layout for the core external-bus demultiplexer.
// The record packs one complete bus cycle as {rw, data, addr}.
package address_bus_demux_pkg;

    typedef enum logic {
        WAIT_HI = 1'b0,
        WAIT_LO = 1'b1
    } cap_state_e;

    localparam int ADDR_LSB    = 0;
    localparam int ADDR_MSB    = 15;
    localparam int DATA_LSB    = 16;
    localparam int DATA_MSB    = 23;
    localparam int RW_BIT      = 24;
    localparam int REC_W       = 25;

    localparam logic PHASE_HI  = 1'b1;
    localparam logic PHASE_LO  = 1'b0;
    localparam int FLAG_RW_BIT = 0;

    function automatic logic [REC_W-1:0] pack_record(input logic rw,
                                                     input logic [7:0] data,
                                                     input logic [15:0] addr);
        return {rw, data, addr};
    endfunction

endpackage

// File: rtl/address_bus_demux_fifo.sv
// First-word-fall-through record FIFO; the head output holds the last popped
// word while empty so a debug consumer never sees stale slots.
module bus_record_fifo
    import address_bus_demux_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = REC_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic             push_accepted
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] last_q;
    logic             pop_ok;

    assign empty  = (wr_ptr_q == rd_ptr_q);
    assign full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop_ok = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push_accepted = push && (!full || pop_ok);
    assign rdata  = empty ? last_q : mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            last_q   <= '0;
        end else begin
            if (push_accepted) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
                last_q   <= mem_q[rd_ptr_q[AW-1:0]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_accepted) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/address_bus_demux.sv
// Reassembles the core's time-multiplexed high/low bus phases into records,
// buffering them for a ready/valid consumer and flagging sequence errors.
module address_bus_demux
    import address_bus_demux_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sample_en,
    input  logic             phase,
    input  logic [7:0]       addr_byte,
    input  logic [7:0]       data_byte,
    output logic             rec_valid,
    input  logic             rec_ready,
    output logic [15:0]      rec_addr,
    output logic [7:0]       rec_data,
    output logic             rec_rw,
    output logic             sync_err,
    output logic             overflow,
    output logic [CNT_W-1:0] rec_count
);

    cap_state_e       state_q, state_d;
    logic [7:0]       hi_q, hi_d;
    logic [7:0]       dat_q, dat_d;
    logic             sync_err_q, sync_err_d;
    logic             overflow_q, overflow_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             fifo_push, fifo_pop, fifo_full, fifo_empty, fifo_accepted;
    logic [REC_W-1:0] fifo_wdata, fifo_rdata;

    always_comb begin
        state_d    = state_q;
        hi_d       = hi_q;
        dat_d      = dat_q;
        sync_err_d = 1'b0;
        fifo_push  = 1'b0;
        fifo_wdata = pack_record(data_byte[FLAG_RW_BIT], dat_q, {hi_q, addr_byte});
        if (sample_en) begin
            unique case (state_q)
                WAIT_HI: begin
                    if (phase == PHASE_HI) begin
                        hi_d    = addr_byte;
                        dat_d   = data_byte;
                        state_d = WAIT_LO;
                    end else begin
                        sync_err_d = 1'b1;
                    end
                end
                WAIT_LO: begin
                    if (phase == PHASE_LO) begin
                        fifo_push = 1'b1;
                        state_d   = WAIT_HI;
                    end else begin
                        // A repeated high phase means we missed a low; keep the newest.
                        hi_d       = addr_byte;
                        dat_d      = data_byte;
                        sync_err_d = 1'b1;
                    end
                end
                default: state_d = WAIT_HI;
            endcase
        end
    end

    assign fifo_pop   = rec_valid && rec_ready;
    assign overflow_d = overflow_q || (fifo_push && !fifo_accepted);
    assign count_d    = fifo_accepted ? count_q + CNT_W'(1) : count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= WAIT_HI;
            hi_q       <= '0;
            dat_q      <= '0;
            sync_err_q <= 1'b0;
            overflow_q <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            hi_q       <= hi_d;
            dat_q      <= dat_d;
            sync_err_q <= sync_err_d;
            overflow_q <= overflow_d;
            count_q    <= count_d;
        end
    end

    bus_record_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (REC_W)
    ) u_fifo (
        .clk           (clk),
        .rst           (rst),
        .push          (fifo_push),
        .wdata         (fifo_wdata),
        .pop           (fifo_pop),
        .rdata         (fifo_rdata),
        .full          (fifo_full),
        .empty         (fifo_empty),
        .push_accepted (fifo_accepted)
    );

    assign rec_valid = !fifo_empty;
    assign rec_addr  = fifo_rdata[ADDR_MSB:ADDR_LSB];
    assign rec_data  = fifo_rdata[DATA_MSB:DATA_LSB];
    assign rec_rw    = fifo_rdata[RW_BIT];
    assign sync_err  = sync_err_q;
    assign overflow  = overflow_q;
    assign rec_count = count_q;

endmodule

// File: tb/tb_address_bus_demux.sv
// Directed bench: expected records go into a queue as low samples are issued;
// a negedge monitor compares every record the consumer actually pops.
module tb_address_bus_demux;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sample_en = 1'b0;
    logic        phase = 1'b0;
    logic [7:0]  addr_byte = '0;
    logic [7:0]  data_byte = '0;
    logic        rec_valid;
    logic        rec_ready = 1'b0;
    logic [15:0] rec_addr;
    logic [7:0]  rec_data;
    logic        rec_rw;
    logic        sync_err;
    logic        overflow;
    logic [15:0] rec_count;

    int testsRun = 0;
    int testsFailed = 0;
    logic [24:0] sbQ[$];
    logic [7:0]  lastHi, lastDat;

    address_bus_demux #(.DEPTH(4), .CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .sample_en (sample_en),
        .phase     (phase),
        .addr_byte (addr_byte),
        .data_byte (data_byte),
        .rec_valid (rec_valid),
        .rec_ready (rec_ready),
        .rec_addr  (rec_addr),
        .rec_data  (rec_data),
        .rec_rw    (rec_rw),
        .sync_err  (sync_err),
        .overflow  (overflow),
        .rec_count (rec_count)
    );

    always #5 clk = ~clk;

    // Monitor: the consumer pops on the next posedge, so compare the head now.
    always @(negedge clk) begin
        if (!rst && rec_valid && rec_ready) begin
            testsRun++;
            if (sbQ.size() == 0) begin
                testsFailed++;
                $display("[TB] FAIL pop_unexpected: got addr=%h data=%h rw=%b, required no record",
                         rec_addr, rec_data, rec_rw);
            end else begin
                logic [24:0] exp;
                exp = sbQ.pop_front();
                if ({rec_rw, rec_data, rec_addr} !== exp) begin
                    testsFailed++;
                    $display("[TB] FAIL record: got rw=%b data=%h addr=%h, required rw=%b data=%h addr=%h",
                             rec_rw, rec_data, rec_addr, exp[24], exp[23:16], exp[15:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic applyReset();
        rst = 1'b1;
        sample_en = 1'b0;
        rec_ready = 1'b0;
        tick();
        rst = 1'b0;
        sbQ.delete();
    endtask

    // One sample_en cycle; results of that edge are visible on return.
    task automatic applyStimulus(input logic ph, input logic [7:0] a, input logic [7:0] d);
        sample_en = 1'b1;
        phase     = ph;
        addr_byte = a;
        data_byte = d;
        tick();
        sample_en = 1'b0;
    endtask

    task automatic sendHigh(input logic [7:0] a, input logic [7:0] d);
        lastHi  = a;
        lastDat = d;
        applyStimulus(1'b1, a, d);
    endtask

    task automatic sendLow(input logic [7:0] a, input logic [7:0] flags, input bit expectKept);
        if (expectKept) sbQ.push_back({flags[0], lastDat, lastHi, a});
        applyStimulus(1'b0, a, flags);
    endtask

    task automatic drain(output int pops);
        pops = 0;
        rec_ready = 1'b1;
        while (rec_valid && pops < 20) begin
            tick();
            pops++;
        end
        rec_ready = 1'b0;
    endtask

    int n;

    initial begin
        // Reset state
        applyReset();
        checkOutput("rst_valid", 32'(rec_valid), 32'd0);
        checkOutput("rst_addr", 32'(rec_addr), 32'd0);
        checkOutput("rst_data", 32'(rec_data), 32'd0);
        checkOutput("rst_rw", 32'(rec_rw), 32'd0);
        checkOutput("rst_sync_err", 32'(sync_err), 32'd0);
        checkOutput("rst_overflow", 32'(overflow), 32'd0);
        checkOutput("rst_count", 32'(rec_count), 32'd0);

        // Basic pair, record visible one clock after the low sample
        sendHigh(8'h12, 8'hAB);
        checkOutput("pair_valid_early", 32'(rec_valid), 32'd0);
        sendLow(8'h34, 8'h01, 1'b1);
        checkOutput("pair_valid", 32'(rec_valid), 32'd1);
        checkOutput("pair_addr", 32'(rec_addr), 32'h1234);
        checkOutput("pair_data", 32'(rec_data), 32'hAB);
        checkOutput("pair_rw", 32'(rec_rw), 32'd1);
        checkOutput("pair_count", 32'(rec_count), 32'd1);
        drain(n);
        checkOutput("pair_pops", 32'(n), 32'd1);
        checkOutput("hold_addr_when_empty", 32'(rec_addr), 32'h1234);

        // Start-up misalignment, then a read cycle; flag bits 7:1 ignored
        applyReset();
        applyStimulus(1'b0, 8'h77, 8'h01);
        checkOutput("align_sync_err", 32'(sync_err), 32'd1);
        checkOutput("align_no_rec", 32'(rec_valid), 32'd0);
        tick();
        checkOutput("align_sync_err_pulse", 32'(sync_err), 32'd0);
        sendHigh(8'h00, 8'h5A);
        sendLow(8'h05, 8'h00, 1'b1);
        checkOutput("read_rw", 32'(rec_rw), 32'd0);
        checkOutput("read_addr", 32'(rec_addr), 32'h0005);
        sendHigh(8'h9C, 8'h3C);
        sendLow(8'hDE, 8'hFE, 1'b1);
        checkOutput("flags_count", 32'(rec_count), 32'd2);
        drain(n);
        checkOutput("flags_pops", 32'(n), 32'd2);

        // Repeated high phase: newest wins, one sync_err
        sendHigh(8'h11, 8'hC1);
        checkOutput("dup_no_err", 32'(sync_err), 32'd0);
        sendHigh(8'h22, 8'hC2);
        checkOutput("dup_sync_err", 32'(sync_err), 32'd1);
        sendLow(8'h33, 8'h01, 1'b1);
        checkOutput("dup_err_cleared", 32'(sync_err), 32'd0);
        checkOutput("dup_addr", 32'(rec_addr), 32'h2233);
        checkOutput("dup_count", 32'(rec_count), 32'd3);
        drain(n);
        checkOutput("dup_pops", 32'(n), 32'd1);

        // Overflow: five pushes into a four-deep FIFO
        applyReset();
        for (int i = 0; i < 5; i++) begin
            sendHigh(8'hA0, 8'(8'h40 + i));
            sendLow(8'(i + 1), 8'(i), i < 4);
            if (i == 3) checkOutput("ovf_not_yet", 32'(overflow), 32'd0);
        end
        checkOutput("ovf_set", 32'(overflow), 32'd1);
        checkOutput("ovf_count", 32'(rec_count), 32'd4);
        tick();
        checkOutput("ovf_sticky", 32'(overflow), 32'd1);
        drain(n);
        checkOutput("ovf_pops", 32'(n), 32'd4);
        checkOutput("ovf_valid_fell", 32'(rec_valid), 32'd0);
        checkOutput("ovf_sticky_after_drain", 32'(overflow), 32'd1);

        // Full FIFO with simultaneous pop and push
        applyReset();
        for (int i = 0; i < 4; i++) begin
            sendHigh(8'hB0, 8'(8'h60 + i));
            sendLow(8'(8'h10 + i), 8'h01, 1'b1);
        end
        sendHigh(8'hCD, 8'hEF);
        rec_ready = 1'b1;
        sendLow(8'h99, 8'h00, 1'b1);
        rec_ready = 1'b0;
        checkOutput("simul_overflow", 32'(overflow), 32'd0);
        checkOutput("simul_count", 32'(rec_count), 32'd5);
        drain(n);
        checkOutput("simul_pops", 32'(n), 32'd4);

        // Reset mid-pair discards the half record
        sendHigh(8'h55, 8'h66);
        applyReset();
        applyStimulus(1'b0, 8'h77, 8'h01);
        checkOutput("midrst_sync_err", 32'(sync_err), 32'd1);
        checkOutput("midrst_no_rec", 32'(rec_valid), 32'd0);
        checkOutput("midrst_count", 32'(rec_count), 32'd0);

        tick();
        checkOutput("scoreboard_empty", 32'(sbQ.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation exceeded time limit");
        $fatal(1, "[TB] timeout");
    end

endmodule
